// File: rtl/aquila_axi_pkg.sv
// rtl/aquila_axi_pkg.sv - shared AXI4-Lite constants and bridge state encoding
package aquila_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_DONE    = 3'd5,
        ST_DRAIN   = 3'd6
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/aquila_dev_axi_bridge_if.sv
// rtl/aquila_dev_axi_bridge_if.sv - AXI4-Lite bus bundle with master/slave views
interface aquila_dev_axi_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/aquila_axi_timeout.sv
// rtl/aquila_axi_timeout.sv - loadable saturating cycle counter with expiry flag
module aquila_axi_timeout #(
    parameter int LIMIT = 1024,
    parameter int WIDTH = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             expired_o
);
    localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

    logic [WIDTH-1:0] count_q, count_d;

    // Saturates at LIMIT so expiry stays asserted until cleared; LIMIT=0 never counts.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != LIM)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (LIMIT != 0) && (count_q == LIM);

endmodule

// File: rtl/aquila_dev_axi_bridge.sv
// rtl/aquila_dev_axi_bridge.sv - core device port to single-beat AXI4-Lite master
module aquila_dev_axi_bridge
    import aquila_axi_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_WIDTH-1:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    dev_strobe_i,
    input  logic [ADDR_WIDTH-1:0]   dev_addr_i,
    input  logic                    dev_rw_i,
    input  logic [DATA_WIDTH/8-1:0] dev_byte_enable_i,
    input  logic [DATA_WIDTH-1:0]   dev_data_i,
    output logic                    dev_data_ready_o,
    output logic [DATA_WIDTH-1:0]   dev_data_o,
    output logic                    dev_err_o,
    aquila_dev_axi_bridge_if.master m_axi
);
    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    logic                    rw_q;
    logic                    awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
    logic                    ready_q, err_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    expired;
    logic                    aw_left, w_left, tmr_en;

    assign aw_left = awvalid_q && !m_axi.awready;
    assign w_left  = wvalid_q && !m_axi.wready;
    assign tmr_en  = (state_q == ST_WR_REQ) || (state_q == ST_WR_RESP) ||
                     (state_q == ST_RD_REQ) || (state_q == ST_RD_RESP);

    aquila_axi_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (state_q == ST_IDLE),
        .load_i     (1'b0),
        .load_val_i ('0),
        .en_i       (tmr_en),
        .expired_o  (expired)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rw_q      <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            // Valids drop only on their own handshake, in every state including DRAIN.
            if (awvalid_q && m_axi.awready) awvalid_q <= 1'b0;
            if (wvalid_q && m_axi.wready)   wvalid_q  <= 1'b0;
            if (arvalid_q && m_axi.arready) arvalid_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (dev_strobe_i) begin
                        addr_q  <= dev_addr_i;
                        rw_q    <= dev_rw_i;
                        wstrb_q <= dev_byte_enable_i;
                        wdata_q <= dev_data_i;
                        if (dev_rw_i) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= ST_WR_REQ;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= ST_RD_REQ;
                        end
                    end
                end
                ST_WR_REQ: begin
                    if (expired) begin
                        bready_q <= 1'b1;
                        ready_q  <= 1'b1;
                        err_q    <= 1'b1;
                        state_q  <= ST_DRAIN;
                    end else if (!aw_left && !w_left) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    // A response in the expiry cycle still counts as a normal completion.
                    if (m_axi.bvalid) begin
                        bready_q <= 1'b0;
                        ready_q  <= 1'b1;
                        err_q    <= resp_is_err(m_axi.bresp);
                        state_q  <= ST_DONE;
                    end else if (expired) begin
                        ready_q <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= ST_DRAIN;
                    end
                end
                ST_RD_REQ: begin
                    if (expired) begin
                        rready_q <= 1'b1;
                        ready_q  <= 1'b1;
                        err_q    <= 1'b1;
                        rdata_q  <= ERR_RDATA;
                        state_q  <= ST_DRAIN;
                    end else if (m_axi.arready) begin
                        rready_q <= 1'b1;
                        state_q  <= ST_RD_RESP;
                    end
                end
                ST_RD_RESP: begin
                    if (m_axi.rvalid) begin
                        rready_q <= 1'b0;
                        ready_q  <= 1'b1;
                        err_q    <= resp_is_err(m_axi.rresp);
                        rdata_q  <= resp_is_err(m_axi.rresp) ? ERR_RDATA : m_axi.rdata;
                        state_q  <= ST_DONE;
                    end else if (expired) begin
                        ready_q <= 1'b1;
                        err_q   <= 1'b1;
                        rdata_q <= ERR_RDATA;
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                ST_DRAIN: begin
                    if (rw_q ? m_axi.bvalid : m_axi.rvalid) begin
                        bready_q <= 1'b0;
                        rready_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_axi.awaddr  = addr_q;
    assign m_axi.awprot  = PROT_DEFAULT;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arprot  = PROT_DEFAULT;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;

    assign dev_data_ready_o = ready_q;
    assign dev_err_o        = err_q;
    assign dev_data_o       = rdata_q;

endmodule
